// File: rtl/multicycle_control_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_control_pkg
// Shared definitions for the multicycle MIPS-style control path: FSM state
// codes, the opcodes the controller understands, ALUOp codes (also consumed
// by the ALU control block) and the datapath mux select encodings.
// -----------------------------------------------------------------------------
package multicycle_control_pkg;

    // Controller state codes; State output carries these values directly.
    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXECUTE   = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_ADDI_EXEC = 4'd10,
        ST_ADDI_WB   = 4'd11
    } state_t;

    // Instruction opcodes (instruction bits [31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALUOp codes handed to the ALU control block.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select.
    localparam logic [1:0] SRCB_REG       = 2'b00;
    localparam logic [1:0] SRCB_FOUR      = 2'b01;
    localparam logic [1:0] SRCB_IMM       = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHIFT = 2'b11;

    // Next-PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for opcodes the controller can execute.
    function automatic logic opcode_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    // True for states whose exit to FETCH retires an instruction.
    function automatic logic is_final_state(input state_t s);
        return (s == ST_MEM_WB) || (s == ST_MEM_WRITE) || (s == ST_R_WB) ||
               (s == ST_BRANCH) || (s == ST_JUMP) || (s == ST_ADDI_WB);
    endfunction

endpackage

// File: rtl/multicycle_control_output_decode.sv
// -----------------------------------------------------------------------------
// control_output_decode
// Purely combinational decode of the registered controller state into the
// datapath control strobes and selects.
// Ports:
//   state       in  4  current state code
//   mem_ready   in  1  memory handshake, qualifies the FETCH write strobes
//   opcode      in  6  instruction opcode, only used to flag illegal opcodes
//   pc_write .. reg_dst   out 1 each  datapath strobes/selects
//   pc_source, alu_op, alu_src_b  out 2 each  mux/ALU selects
//   illegal     out 1  high in DECODE when the opcode is unsupported
// -----------------------------------------------------------------------------
module control_output_decode
    import multicycle_control_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic       reg_write,
    output logic       reg_dst,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic       illegal
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        alu_src_a     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_op        = ALUOP_ADD;
        alu_src_b     = SRCB_REG;
        illegal       = 1'b0;

        case (state_t'(state))
            ST_FETCH: begin
                mem_read  = 1'b1;
                // PC and IR only load on the cycle the fetch actually
                // completes, so a stalled fetch never advances PC twice.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALUOP_ADD;
                pc_source = PCSRC_ALU;
            end
            ST_DECODE: begin
                // Speculative branch target: PC + (imm << 2).
                alu_src_b = SRCB_IMM_SHIFT;
                alu_op    = ALUOP_ADD;
                illegal   = !opcode_legal(opcode);
            end
            ST_MEM_ADDR, ST_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            ST_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_REG;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            ST_ADDI_WB: begin
                reg_write = 1'b1;
            end
            default: begin
                // Unreachable codes drive nothing; the FSM recovers to FETCH.
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Moore-style control unit for a multicycle MIPS subset (lw, sw, R-type,
// addi, beq, j) with a memory ready handshake and a retired-instruction
// counter.
// Ports:
//   Clock        in   1   rising-edge clock
//   Reset_n      in   1   asynchronous active-low reset
//   Opcode       in   6   instruction bits [31:26] from the IR
//   Mem_Ready    in   1   memory access completes when high
//   PCWrite .. RegDst  out 1 each  datapath strobes/selects
//   PCSource, ALUOp, ALUSrcB  out 2 each  mux/ALU selects
//   Illegal      out  1   pulse in DECODE on an unsupported opcode
//   State        out  4   current state code
//   Instr_Count  out 32   retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [5:0]  Opcode,
    input  logic        Mem_Ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        IRWrite,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        RegDst,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ALUSrcB,
    output logic        Illegal,
    output logic [3:0]  State,
    output logic [31:0] Instr_Count
);

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] instr_count_reg;
    logic        retire;

    // Decoder outputs before reset gating.
    logic       pc_write_raw;
    logic       pc_write_cond_raw;
    logic       iord_raw;
    logic       mem_read_raw;
    logic       mem_write_raw;
    logic       mem_to_reg_raw;
    logic       ir_write_raw;
    logic       alu_src_a_raw;
    logic       reg_write_raw;
    logic       reg_dst_raw;
    logic [1:0] pc_source_raw;
    logic [1:0] alu_op_raw;
    logic [1:0] alu_src_b_raw;
    logic       illegal_raw;

    // State register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; Mem_Ready only gates transitions.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH: begin
                if (Mem_Ready) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (Opcode)
                    OP_RTYPE:      state_next = ST_EXECUTE;
                    OP_LW, OP_SW:  state_next = ST_MEM_ADDR;
                    OP_BEQ:        state_next = ST_BRANCH;
                    OP_J:          state_next = ST_JUMP;
                    OP_ADDI:       state_next = ST_ADDI_EXEC;
                    default:       state_next = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: begin
                // Opcode comes from the IR and is stable here; anything
                // other than lw/sw can only arise from corruption, so bail
                // out to FETCH rather than touch memory.
                if (Opcode == OP_LW)      state_next = ST_MEM_READ;
                else if (Opcode == OP_SW) state_next = ST_MEM_WRITE;
                else                      state_next = ST_FETCH;
            end
            ST_MEM_READ: begin
                if (Mem_Ready) state_next = ST_MEM_WB;
            end
            ST_MEM_WRITE: begin
                if (Mem_Ready) state_next = ST_FETCH;
            end
            ST_MEM_WB:    state_next = ST_FETCH;
            ST_EXECUTE:   state_next = ST_R_WB;
            ST_R_WB:      state_next = ST_FETCH;
            ST_BRANCH:    state_next = ST_FETCH;
            ST_JUMP:      state_next = ST_FETCH;
            ST_ADDI_EXEC: state_next = ST_ADDI_WB;
            ST_ADDI_WB:   state_next = ST_FETCH;
            default:      state_next = ST_FETCH;
        endcase
    end

    // An instruction retires when a final state hands back to FETCH; a
    // stalled MEM_WRITE stays put and illegal opcodes never reach a final
    // state, so neither counts.
    assign retire = is_final_state(state_reg) && (state_next == ST_FETCH);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            instr_count_reg <= '0;
        end else if (retire) begin
            instr_count_reg <= instr_count_reg + 32'd1;
        end
    end

    control_output_decode u_decode (
        .state         (state_reg),
        .mem_ready     (Mem_Ready),
        .opcode        (Opcode),
        .pc_write      (pc_write_raw),
        .pc_write_cond (pc_write_cond_raw),
        .iord          (iord_raw),
        .mem_read      (mem_read_raw),
        .mem_write     (mem_write_raw),
        .mem_to_reg    (mem_to_reg_raw),
        .ir_write      (ir_write_raw),
        .alu_src_a     (alu_src_a_raw),
        .reg_write     (reg_write_raw),
        .reg_dst       (reg_dst_raw),
        .pc_source     (pc_source_raw),
        .alu_op        (alu_op_raw),
        .alu_src_b     (alu_src_b_raw),
        .illegal       (illegal_raw)
    );

    // The reset state is FETCH, which would otherwise drive MemRead etc.;
    // gate every control output so nothing reaches the datapath while
    // Reset_n is low, independent of the clock.
    assign PCWrite     = Reset_n & pc_write_raw;
    assign PCWriteCond = Reset_n & pc_write_cond_raw;
    assign IorD        = Reset_n & iord_raw;
    assign MemRead     = Reset_n & mem_read_raw;
    assign MemWrite    = Reset_n & mem_write_raw;
    assign MemtoReg    = Reset_n & mem_to_reg_raw;
    assign IRWrite     = Reset_n & ir_write_raw;
    assign ALUSrcA     = Reset_n & alu_src_a_raw;
    assign RegWrite    = Reset_n & reg_write_raw;
    assign RegDst      = Reset_n & reg_dst_raw;
    assign PCSource    = {2{Reset_n}} & pc_source_raw;
    assign ALUOp       = {2{Reset_n}} & alu_op_raw;
    assign ALUSrcB     = {2{Reset_n}} & alu_src_b_raw;
    assign Illegal     = Reset_n & illegal_raw;

    assign State       = state_reg;
    assign Instr_Count = instr_count_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Directed bench for multicycle_control. Control outputs are packed into one
// 16-bit vector {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
// IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB} and compared
// against hand-computed per-state values.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    logic        Clock;
    logic        Reset_n;
    logic [5:0]  Opcode;
    logic        Mem_Ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic        IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0]  PCSource, ALUOp, ALUSrcB;
    logic        Illegal;
    logic [3:0]  State;
    logic [31:0] Instr_Count;

    logic [15:0] ctrl;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_count = 32'd0;
    int          rw_events = 0;

    // Hand-computed control vectors.
    localparam logic [15:0] C_FETCH      = 16'h9201;
    localparam logic [15:0] C_FETCH_WAIT = 16'h1001;
    localparam logic [15:0] C_DECODE     = 16'h0003;
    localparam logic [15:0] C_MEM_ADDR   = 16'h0102;
    localparam logic [15:0] C_MEM_READ   = 16'h3000;
    localparam logic [15:0] C_MEM_WB     = 16'h0480;
    localparam logic [15:0] C_MEM_WRITE  = 16'h2800;
    localparam logic [15:0] C_EXECUTE    = 16'h0108;
    localparam logic [15:0] C_R_WB       = 16'h00C0;
    localparam logic [15:0] C_BRANCH     = 16'h4114;
    localparam logic [15:0] C_JUMP       = 16'h8020;
    localparam logic [15:0] C_ADDI_EXEC  = 16'h0102;
    localparam logic [15:0] C_ADDI_WB    = 16'h0080;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

    multicycle_control dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .Opcode      (Opcode),
        .Mem_Ready   (Mem_Ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .ALUSrcB     (ALUSrcB),
        .Illegal     (Illegal),
        .State       (State),
        .Instr_Count (Instr_Count)
    );

    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                   IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Counts cycles in which RegWrite was high going into an edge.
    always @(posedge Clock) if (RegWrite) rw_events <= rw_events + 1;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Mem_Ready = 1'b1; Opcode = RT;
        #2;
        checks++; if (State !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", State); end
        checks++; if (Instr_Count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", Instr_Count); end
        checks++; if (ctrl !== 16'h0000) begin errors++; $display("FAIL reset_ctrl: got %h want 0000", ctrl); end
        checks++; if (Illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", Illegal); end
        tick();
        checks++; if (State !== 4'd0 || ctrl !== 16'h0000) begin errors++; $display("FAIL reset_hold: state %0d ctrl %h want 0 0000", State, ctrl); end
        Reset_n = 1'b1;
        #1;
        checks++; if (ctrl !== C_FETCH) begin errors++; $display("FAIL reset_release_ctrl: got %h want %h", ctrl, C_FETCH); end
        $display("test_reset done");
    endtask

    task automatic test_reset_mid();
        int rw0;
        logic [3:0] st [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        Opcode = LW; Mem_Ready = 1'b1;
        rw0 = rw_events;
        tick(); tick(); tick();
        checks++; if (State !== 4'd3) begin errors++; $display("FAIL mid_pre_state: got %0d want 3", State); end
        Reset_n = 1'b0;
        #1;
        checks++; if (State !== 4'd0 || ctrl !== 16'h0000) begin errors++; $display("FAIL mid_reset: state %0d ctrl %h want 0 0000", State, ctrl); end
        checks++; if (Instr_Count !== 32'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", Instr_Count); end
        tick(); tick();
        checks++; if (State !== 4'd0 || MemWrite !== 1'b0) begin errors++; $display("FAIL mid_hold: state %0d memwrite %b want 0 0", State, MemWrite); end
        checks++; if (rw_events !== rw0) begin errors++; $display("FAIL mid_regwrite: got %0d events want 0", rw_events - rw0); end
        Reset_n = 1'b1;
        #1;
        checks++; if (State !== 4'd0 || ctrl !== C_FETCH) begin errors++; $display("FAIL mid_release: state %0d ctrl %h want 0 %h", State, ctrl, C_FETCH); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (State !== st[i]) begin errors++; $display("FAIL mid_rerun step %0d: state %0d want %0d", i, State, st[i]); end
        end
        exp_count++;
        checks++; if (Instr_Count !== exp_count) begin errors++; $display("FAIL mid_rerun_count: got %0d want %0d", Instr_Count, exp_count); end
        $display("test_reset_mid done");
    endtask

    task automatic test_lw();
        logic [3:0]  st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        logic [15:0] cv [6] = '{C_FETCH, C_DECODE, C_MEM_ADDR, C_MEM_READ, C_MEM_WB, C_FETCH};
        int rw = 0;
        Opcode = LW; Mem_Ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (State !== st[i] || ctrl !== cv[i]) begin errors++; $display("FAIL lw cycle %0d: state %0d ctrl %h want %0d %h", i, State, ctrl, st[i], cv[i]); end
            if (RegWrite === 1'b1) rw++;
            if (i < 5) tick();
        end
        exp_count++;
        checks++; if (Instr_Count !== exp_count) begin errors++; $display("FAIL lw_count: got %0d want %0d", Instr_Count, exp_count); end
        checks++; if (rw !== 1) begin errors++; $display("FAIL lw_regwrite_cycles: got %0d want 1", rw); end
        $display("test_lw done");
    endtask

    task automatic test_fetch_wait();
        Opcode = JMP; Mem_Ready = 1'b0;
        #1;
        checks++; if (State !== 4'd0 || ctrl !== C_FETCH_WAIT) begin errors++; $display("FAIL fetch_wait0: state %0d ctrl %h want 0 %h", State, ctrl, C_FETCH_WAIT); end
        tick();
        checks++; if (State !== 4'd0 || ctrl !== C_FETCH_WAIT) begin errors++; $display("FAIL fetch_wait1: state %0d ctrl %h want 0 %h", State, ctrl, C_FETCH_WAIT); end
        Mem_Ready = 1'b1;
        #1;
        checks++; if (ctrl !== C_FETCH) begin errors++; $display("FAIL fetch_ready: ctrl %h want %h", ctrl, C_FETCH); end
        tick();
        checks++; if (State !== 4'd1) begin errors++; $display("FAIL fetch_to_decode: state %0d want 1", State); end
        tick();
        checks++; if (State !== 4'd9 || ctrl !== C_JUMP) begin errors++; $display("FAIL fetch_jump: state %0d ctrl %h want 9 %h", State, ctrl, C_JUMP); end
        tick();
        exp_count++;
        checks++; if (State !== 4'd0 || Instr_Count !== exp_count) begin errors++; $display("FAIL fetch_done: state %0d count %0d want 0 %0d", State, Instr_Count, exp_count); end
        $display("test_fetch_wait done");
    endtask

    task automatic test_sw_wait();
        logic [3:0]  st  [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
        logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] cv  [8] = '{C_FETCH, C_DECODE, C_MEM_ADDR, C_MEM_WRITE, C_MEM_WRITE,
                                 C_MEM_WRITE, C_MEM_WRITE, C_FETCH};
        int mw = 0;
        int rw0 = rw_events;
        Opcode = SW;
        for (int i = 0; i < 8; i++) begin
            Mem_Ready = rdy[i];
            #1;
            checks++; if (State !== st[i] || ctrl !== cv[i]) begin errors++; $display("FAIL sw cycle %0d: state %0d ctrl %h want %0d %h", i, State, ctrl, st[i], cv[i]); end
            if (MemWrite === 1'b1) mw++;
            if (i < 7) tick();
        end
        exp_count++;
        checks++; if (mw !== 4) begin errors++; $display("FAIL sw_memwrite_cycles: got %0d want 4", mw); end
        checks++; if (rw_events !== rw0) begin errors++; $display("FAIL sw_regwrite: got %0d events want 0", rw_events - rw0); end
        checks++; if (Instr_Count !== exp_count) begin errors++; $display("FAIL sw_count: got %0d want %0d", Instr_Count, exp_count); end
        $display("test_sw_wait done");
    endtask

    task automatic test_alu_types();
        logic [5:0]  op [8] = '{RT, RT, RT, RT, ADDI, ADDI, ADDI, ADDI};
        logic [3:0]  st [8] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd10, 4'd11};
        logic [15:0] cv [8] = '{C_FETCH, C_DECODE, C_EXECUTE, C_R_WB,
                                C_FETCH, C_DECODE, C_ADDI_EXEC, C_ADDI_WB};
        Mem_Ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Opcode = op[i];
            #1;
            checks++; if (State !== st[i] || ctrl !== cv[i]) begin errors++; $display("FAIL alu cycle %0d: state %0d ctrl %h want %0d %h", i, State, ctrl, st[i], cv[i]); end
            tick();
        end
        exp_count = exp_count + 32'd2;
        checks++; if (State !== 4'd0 || Instr_Count !== exp_count) begin errors++; $display("FAIL alu_done: state %0d count %0d want 0 %0d", State, Instr_Count, exp_count); end
        $display("test_alu_types done");
    endtask

    task automatic test_branch_jump();
        logic [5:0]  op [6] = '{BEQ, BEQ, BEQ, JMP, JMP, JMP};
        logic [3:0]  st [6] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9};
        logic [15:0] cv [6] = '{C_FETCH, C_DECODE, C_BRANCH, C_FETCH, C_DECODE, C_JUMP};
        Mem_Ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            Opcode = op[i];
            #1;
            checks++; if (State !== st[i] || ctrl !== cv[i]) begin errors++; $display("FAIL bj cycle %0d: state %0d ctrl %h want %0d %h", i, State, ctrl, st[i], cv[i]); end
            if (i == 2) begin
                checks++; if (PCSource !== 2'b01) begin errors++; $display("FAIL beq_pcsource: got %b want 01", PCSource); end
            end
            if (i == 5) begin
                checks++; if (PCSource !== 2'b10) begin errors++; $display("FAIL j_pcsource: got %b want 10", PCSource); end
            end
            tick();
        end
        exp_count = exp_count + 32'd2;
        checks++; if (State !== 4'd0 || Instr_Count !== exp_count) begin errors++; $display("FAIL bj_done: state %0d count %0d want 0 %0d", State, Instr_Count, exp_count); end
        $display("test_branch_jump done");
    endtask

    task automatic test_illegal();
        Opcode = 6'b111111; Mem_Ready = 1'b1;
        #1;
        checks++; if (State !== 4'd0 || Illegal !== 1'b0) begin errors++; $display("FAIL illegal_fetch: state %0d illegal %b want 0 0", State, Illegal); end
        tick();
        checks++; if (State !== 4'd1 || Illegal !== 1'b1) begin errors++; $display("FAIL illegal_decode: state %0d illegal %b want 1 1", State, Illegal); end
        tick();
        checks++; if (State !== 4'd0 || Illegal !== 1'b0) begin errors++; $display("FAIL illegal_return: state %0d illegal %b want 0 0", State, Illegal); end
        checks++; if (Instr_Count !== exp_count) begin errors++; $display("FAIL illegal_count: got %0d want %0d", Instr_Count, exp_count); end
        $display("test_illegal done");
    endtask

    task automatic test_wrap();
        Opcode = RT; Mem_Ready = 1'b1;
        dut.instr_count_reg = 32'hFFFF_FFFF;
        #1;
        checks++; if (Instr_Count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffffffff", Instr_Count); end
        tick(); tick(); tick(); tick();
        checks++; if (State !== 4'd0 || Instr_Count !== 32'd0) begin errors++; $display("FAIL wrap: state %0d count %h want 0 00000000", State, Instr_Count); end
        $display("test_wrap done");
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_lw();
        test_fetch_wait();
        test_sw_wait();
        test_alu_types();
        test_branch_jump();
        test_illegal();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
